mavg_rd_ctrl: RTL and testbench
===============================

MAVG_RD_CTRL -- requirements
Module: mavg_rd_ctrl

Interface
REQ-001 Parameter D_WIDTH, default 8: sample width; matches the FIFO data width.
REQ-002 Parameter LOG2_N, default 2: log2 of the moving-average window length N (N=4 by default).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 r_clk  in  1: read-domain clock; all state updates on its rising edge.
REQ-005 r_rstn  in  1: asynchronous active-low reset.
REQ-006 en  in  1: enables draining of the FIFO.
REQ-007 clr  in  1: synchronous window clear.
REQ-008 fifo_empty  in  1: FIFO empty flag.
REQ-009 fifo_rd_data  in  D_WIDTH: FIFO data at the current read address, valid combinationally.
REQ-010 fifo_r_inc  out  1: FIFO pop strobe.
REQ-011 avg_data  out  D_WIDTH: window average.
REQ-012 avg_valid  out  1: avg_data valid.
REQ-013 avg_ready  in  1: downstream accepts avg_data.
REQ-014 win_full  out  1: the window holds N samples.

Function
REQ-015 The FSM SHALL have three states: IDLE, FILL (count<N) and RUN (count==N).
REQ-016 State transitions: IDLE->FILL when en=1 and count<N; IDLE->RUN when en=1 and count==N; FILL->RUN on the pop that makes count==N; FILL/RUN->IDLE when en=0; window, sum and count are retained in IDLE.
REQ-017 pop SHALL be asserted when all hold: state!=IDLE, fifo_empty=0, clr=0, and (avg_valid=0 or avg_ready=1).
REQ-018 fifo_r_inc SHALL equal pop combinationally; fifo_rd_data is captured on the same edge.
REQ-019 The window SHALL be a circular buffer of N entries with write pointer wptr (LOG2_N bits, wraps from N-1 to 0); each pop writes window[wptr] and increments wptr.
REQ-020 The running sum SHALL be D_WIDTH+LOG2_N bits wide; on a pop, sum_next = sum + new - old, where old = window[wptr] if count==N and 0 otherwise; the sum never overflows.
REQ-021 count SHALL increment on each pop and saturate at N.
REQ-022 On a pop with count_next==N, the block SHALL set avg_valid<=1 and avg_data<=sum_next>>LOG2_N (truncating) at the next edge; latency is 1 cycle from the pop.
REQ-023 avg_valid and avg_data SHALL hold stable until avg_valid&&avg_ready; on that handshake without a new result, avg_valid<=0.
REQ-024 A handshake and a new result on the same edge SHALL load the new result with avg_valid remaining 1, giving a throughput of 1 per cycle.
REQ-025 When avg_valid=1 and avg_ready=0, no pop SHALL occur (backpressure); FIFO contents are not lost.
REQ-026 When fifo_empty=1, no pop SHALL occur and all state SHALL hold.
REQ-027 clr=1 SHALL take priority over pop: count, sum, wptr and avg_valid go to 0, any pending output is dropped, and next state is FILL if en=1, otherwise IDLE.
REQ-028 win_full SHALL equal (count==N), registered.

Reset
REQ-029 r_rstn low SHALL immediately force: state=IDLE, count=0, sum=0, wptr=0, avg_valid=0, avg_data=0, win_full=0; fifo_r_inc=0 while in reset.
REQ-030 Window contents are not required to reset; count gating makes stale entries unobservable.
REQ-031 Reset asserted mid-operation SHALL abort any pending output; after release the block restarts in FILL.

Structure
REQ-032 Package mavg_pkg SHALL hold the state enumeration (IDLE, FILL, RUN) and the D_WIDTH and LOG2_N defaults.
REQ-033 Sub-module mavg_window SHALL hold the circular register file: write port (data, wptr, we) and read port (old at wptr).
REQ-034 mavg_rd_ctrl SHALL contain the FSM, pop logic, sum/count and the output register.

Verification (D_WIDTH=8, N=4)
REQ-035 Fill: en=1, FIFO holds 10,20,30,40, avg_ready=1 -> 4 pops; avg_valid rises the cycle after the 4th pop with avg_data=25; win_full=1.
REQ-036 Slide: continue with 50 -> avg_data=35; then 255,255,255,255 -> final avg_data=255, with no sum overflow.
REQ-037 Backpressure: avg_ready=0 with a result pending and FIFO non-empty -> fifo_r_inc=0; avg_data is held; the first pop occurs on the avg_ready=1 cycle.
REQ-038 Empty/en: fifo_empty=1 for 5 cycles, then en=0 for 5 cycles -> no pops and state held; resume produces the correct sliding average.
REQ-039 clr in RUN with avg_valid=1 -> avg_valid=0 next cycle; the next 3 pops produce no output; the 4th pop yields the average of the new samples only.
REQ-040 Async reset asserted mid-RUN between edges -> outputs go to 0 immediately; after release, the sequence 4,4,4,4 gives avg_data=4.

Source files
------------

// File: rtl/mavg_pkg.sv
// Shared types and default parameters for the moving-average read controller.
package mavg_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int LOG2_N_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/mavg_window.sv
// Circular sample window: one write port at wptr, combinational read of the
// entry about to be overwritten.
module mavg_window #(
  parameter int D_WIDTH = 8,
  parameter int LOG2_N  = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LOG2_N-1:0]  wptr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] old_data
);

  localparam int N = 1 << LOG2_N;

  // No reset: stale entries are masked by the sample count in the controller.
  logic [D_WIDTH-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wptr] <= wdata;
    end
  end

  assign old_data = mem_q[wptr];

endmodule

// File: rtl/mavg_rd_ctrl.sv
// FIFO read-side controller computing an N-sample moving average with a
// ready/valid output register.
module mavg_rd_ctrl
  import mavg_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int LOG2_N  = LOG2_N_DEF
) (
  input  logic               r_clk,
  input  logic               r_rstn,
  input  logic               en,
  input  logic               clr,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_rd_data,
  output logic               fifo_r_inc,
  output logic [D_WIDTH-1:0] avg_data,
  output logic               avg_valid,
  input  logic               avg_ready,
  output logic               win_full
);

  localparam int N       = 1 << LOG2_N;
  localparam int S_WIDTH = D_WIDTH + LOG2_N;
  localparam logic [LOG2_N:0] COUNT_FULL = (LOG2_N+1)'(N);

  state_t               state_q, state_d;
  logic [LOG2_N:0]      count_q, count_d;
  logic [S_WIDTH-1:0]   sum_q, sum_d;
  logic [LOG2_N-1:0]    wptr_q, wptr_d;
  logic                 avg_valid_q, avg_valid_d;
  logic [D_WIDTH-1:0]   avg_data_q, avg_data_d;
  logic                 win_full_q, win_full_d;

  logic                 pop;
  logic [D_WIDTH-1:0]   old_data;
  logic [S_WIDTH-1:0]   old_term;
  logic [S_WIDTH-1:0]   sum_shift;

  mavg_window #(
    .D_WIDTH (D_WIDTH),
    .LOG2_N  (LOG2_N)
  ) u_window (
    .clk      (r_clk),
    .we       (pop),
    .wptr     (wptr_q),
    .wdata    (fifo_rd_data),
    .old_data (old_data)
  );

  always_comb begin
    pop = (state_q != IDLE) && !fifo_empty && !clr && (!avg_valid_q || avg_ready);
    // Until the window is full the overwritten slot holds no live sample.
    old_term = (count_q == COUNT_FULL) ? {{LOG2_N{1'b0}}, old_data} : '0;

    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    wptr_d      = wptr_q;
    avg_valid_d = avg_valid_q;
    avg_data_d  = avg_data_q;
    sum_shift   = '0;

    if (clr) begin
      count_d     = '0;
      sum_d       = '0;
      wptr_d      = '0;
      avg_valid_d = 1'b0;
      state_d     = en ? FILL : IDLE;
    end else begin
      if (pop) begin
        sum_d  = sum_q + {{LOG2_N{1'b0}}, fifo_rd_data} - old_term;
        wptr_d = wptr_q + 1'b1;
        if (count_q != COUNT_FULL) begin
          count_d = count_q + 1'b1;
        end
      end
      sum_shift = sum_d >> LOG2_N;

      // A new result replaces one being handed off on the same edge.
      if (pop && (count_d == COUNT_FULL)) begin
        avg_valid_d = 1'b1;
        avg_data_d  = sum_shift[D_WIDTH-1:0];
      end else if (avg_valid_q && avg_ready) begin
        avg_valid_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = (count_q == COUNT_FULL) ? RUN : FILL;
          end
        end
        FILL: begin
          if (!en) begin
            state_d = IDLE;
          end else if (count_d == COUNT_FULL) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!en) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    win_full_d = (count_d == COUNT_FULL);
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      sum_q       <= '0;
      wptr_q      <= '0;
      avg_valid_q <= 1'b0;
      avg_data_q  <= '0;
      win_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      wptr_q      <= wptr_d;
      avg_valid_q <= avg_valid_d;
      avg_data_q  <= avg_data_d;
      win_full_q  <= win_full_d;
    end
  end

  assign fifo_r_inc = pop;
  assign avg_valid  = avg_valid_q;
  assign avg_data   = avg_data_q;
  assign win_full   = win_full_q;

endmodule

// File: tb/tb_mavg_rd_ctrl.sv
// Directed bench for mavg_rd_ctrl: behavioural FIFO in front, scoreboard on the
// averaged output stream.
module tb_mavg_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rstn = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       avg_ready = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_r_inc;
  logic [7:0] avg_data;
  logic       avg_valid;
  logic       win_full;

  always #5 r_clk = ~r_clk;

  mavg_rd_ctrl #(.D_WIDTH(8), .LOG2_N(2)) dut (
    .r_clk        (r_clk),
    .r_rstn       (r_rstn),
    .en           (en),
    .clr          (clr),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_r_inc   (fifo_r_inc),
    .avg_data     (avg_data),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .win_full     (win_full)
  );

  // Behavioural FIFO
  logic [7:0] fmem [64];
  int frd = 0;
  int fwr = 0;
  int pop_cnt = 0;
  assign fifo_empty   = (frd == fwr);
  assign fifo_rd_data = fmem[frd[5:0]];

  always @(posedge r_clk) begin
    if (fifo_r_inc) begin
      frd     <= frd + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output is compared with the next expected average
  always @(negedge r_clk) begin : monitor
    logic [7:0] e;
    if (r_rstn && avg_valid && avg_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", avg_data);
      end else begin
        e = exp_q.pop_front();
        $display("txn avg_data=%0d expected=%0d", avg_data, e);
        check("avg_data", {24'd0, avg_data}, {24'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input bit has_exp, input logic [7:0] e);
    fmem[fwr[5:0]] = v;
    fwr++;
    if (has_exp) exp_q.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while ((frd != fwr || exp_q.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    check("drain_in_time", {31'd0, (c < maxc)}, 32'd1);
    step();
    step();
  endtask

  task automatic wait_valid(input int maxc);
    int c;
    c = 0;
    while (!avg_valid && c < maxc) begin
      step();
      c++;
    end
    check("wait_valid", {31'd0, avg_valid}, 32'd1);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("rst_avg_data", {24'd0, avg_data}, 32'd0);
    check("rst_win_full", {31'd0, win_full}, 32'd0);
    check("rst_fifo_r_inc", {31'd0, fifo_r_inc}, 32'd0);
    step();
    step();
    r_rstn = 1'b1;
    en = 1'b1;
    avg_ready = 1'b1;

    // Fill: 10,20,30,40 -> 25
    push(8'd10, 1'b0, 8'd0);
    push(8'd20, 1'b0, 8'd0);
    push(8'd30, 1'b0, 8'd0);
    push(8'd40, 1'b1, 8'd25);
    drain(30);
    check("fill_win_full", {31'd0, win_full}, 32'd1);
    check("fill_pops", pop_cnt, 32'd4);

    // Slide, including a full window of 255
    push(8'd50, 1'b1, 8'd35);
    push(8'd255, 1'b1, 8'd93);
    push(8'd255, 1'b1, 8'd150);
    push(8'd255, 1'b1, 8'd203);
    push(8'd255, 1'b1, 8'd255);
    drain(30);
    check("slide_pops", pop_cnt, 32'd9);

    // Backpressure: result 191 pending, sample 2 must wait
    avg_ready = 1'b0;
    push(8'd1, 1'b1, 8'd191);
    wait_valid(10);
    push(8'd2, 1'b1, 8'd128);
    repeat (5) begin
      @(negedge r_clk);
      check("bp_no_pop", {31'd0, fifo_r_inc}, 32'd0);
      check("bp_hold_data", {24'd0, avg_data}, 32'd191);
    end
    step();
    avg_ready = 1'b1;
    @(negedge r_clk);
    check("bp_pop_on_ready", {31'd0, fifo_r_inc}, 32'd1);
    drain(30);
    check("bp_pops", pop_cnt, 32'd11);

    // Empty FIFO, then en low with data waiting
    repeat (5) step();
    check("empty_pops", pop_cnt, 32'd11);
    check("empty_valid", {31'd0, avg_valid}, 32'd0);
    en = 1'b0;
    step();
    step();
    push(8'd100, 1'b1, 8'd89);
    push(8'd100, 1'b1, 8'd50);
    push(8'd100, 1'b1, 8'd75);
    repeat (5) begin
      @(negedge r_clk);
      check("en_low_no_pop", {31'd0, fifo_r_inc}, 32'd0);
    end
    check("en_low_pops", pop_cnt, 32'd11);
    step();
    en = 1'b1;
    drain(30);
    check("resume_pops", pop_cnt, 32'd14);

    // Clear while a result (77) is pending
    avg_ready = 1'b0;
    push(8'd8, 1'b0, 8'd0);
    wait_valid(10);
    check("clr_pending_data", {24'd0, avg_data}, 32'd77);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge r_clk);
    check("clr_valid", {31'd0, avg_valid}, 32'd0);
    check("clr_win_full", {31'd0, win_full}, 32'd0);
    avg_ready = 1'b1;
    push(8'd4, 1'b0, 8'd0);
    push(8'd8, 1'b0, 8'd0);
    push(8'd12, 1'b0, 8'd0);
    repeat (6) step();
    check("clr_refill_pops", pop_cnt, 32'd18);
    check("clr_refill_valid", {31'd0, avg_valid}, 32'd0);
    push(8'd16, 1'b1, 8'd10);
    drain(30);
    check("clr_win_full_again", {31'd0, win_full}, 32'd1);

    // Asynchronous reset with a result (59) pending
    avg_ready = 1'b0;
    push(8'd200, 1'b0, 8'd0);
    wait_valid(10);
    check("rst_pending_data", {24'd0, avg_data}, 32'd59);
    @(posedge r_clk);
    #2;
    r_rstn = 1'b0;
    #1;
    check("arst_avg_valid", {31'd0, avg_valid}, 32'd0);
    check("arst_avg_data", {24'd0, avg_data}, 32'd0);
    check("arst_win_full", {31'd0, win_full}, 32'd0);
    check("arst_fifo_r_inc", {31'd0, fifo_r_inc}, 32'd0);
    repeat (2) step();
    #2;
    r_rstn = 1'b1;
    avg_ready = 1'b1;
    push(8'd4, 1'b0, 8'd0);
    push(8'd4, 1'b0, 8'd0);
    push(8'd4, 1'b0, 8'd0);
    push(8'd4, 1'b1, 8'd4);
    drain(30);
    check("post_rst_win_full", {31'd0, win_full}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
